midi_event_tx: RTL and testbench
================================

# midi_event_tx

Downstream stage of the staff playback path. Accepts one-cycle note events (note, velocity, on/off status, valid strobe) from the staff playback block and queues them in a small FIFO. Frames each event as a 3-byte MIDI channel message and serializes it onto a single MIDI-out line at 31250 baud (8N1, LSB first). Event production and line timing are fully decoupled: the producer never stalls, and overflow is flagged.

## Interface
Parameters:
- CLOCK_FREQUENCY, 100_000_000, system clock in Hz
- BAUD_RATE, 31250, MIDI bit rate
- FIFO_DEPTH, 8, event queue depth (power of 2, ≥2)
- CHANNEL, 0, MIDI channel 0–15 placed in status low nibble
- RUNNING_STATUS, 0, 1 = omit status byte when equal to last transmitted status

Ports:
- clk_in  input  1  system clock; all logic on posedge
- rst_in  input  1  reset, asynchronous, active-low
- event_valid_in  input  1  one-cycle event strobe
- event_note_in  input  8  note number; bit 7 ignored
- event_velocity_in  input  8  velocity; bit 7 ignored
- event_status_in  input  1  1 = note-on, 0 = note-off
- midi_tx_out  output  1  serial MIDI line, idle high
- busy_out  output  1  high while FIFO non-empty or a frame is in flight
- fifo_count_out  output  $clog2(FIFO_DEPTH)+1  queued events, excluding the one being sent
- overflow_out  output  1  sticky; set when an event is dropped

## Operation
- Reset (rst_in low, async): midi_tx_out=1, busy_out=0, fifo_count_out=0, overflow_out=0, FIFO emptied, FSM=IDLE, last-status register cleared to 0x00. Reset mid-frame aborts immediately; the line returns high.
- Push: on event_valid_in, store {note[6:0], velocity[6:0], status}. Accept if count<FIFO_DEPTH, or if a pop occurs in the same cycle. Otherwise drop the event and set overflow_out.
- Message construction at pop:
  - byte0 = {status ? 4'h9 : 4'h8, CHANNEL[3:0]}
  - byte1 = note[6:0] with bit7=0
  - byte2 = velocity[6:0] with bit7=0
  - Note-off carries the supplied velocity.
  - With RUNNING_STATUS=1 and byte0 equal to the last-status register, skip byte0. The last-status register updates at every pop.
- FSM states:
  - IDLE: stay while FIFO empty. Otherwise pop, latch bytes, set byte index, go to START.
  - START: drive 0 for BIT_CYCLES, go to DATA.
  - DATA: drive bits 0..7 in turn, BIT_CYCLES each, go to STOP.
  - STOP: drive 1 for BIT_CYCLES. If more bytes remain in the message, go to START for the next byte. Else if FIFO non-empty, pop and go to START. Else go to IDLE.
- BIT_CYCLES = CLOCK_FREQUENCY/BAUD_RATE, computed as an integer (3200 at defaults). The bit counter is a $clog2(BIT_CYCLES)-bit counter that wraps at BIT_CYCLES-1.

## Timing
- Event sampled at edge k into an empty, idle block: midi_tx_out falls after edge k+1.
- Each bit lasts exactly BIT_CYCLES cycles.
- Back-to-back bytes and messages have no idle gap. Byte = 10·BIT_CYCLES (32000 cycles); 3-byte message = 96000 cycles.
- fifo_count_out and overflow_out are registered and update the edge after the push or pop.
- busy_out falls on the cycle IDLE is entered with the FIFO empty.

## Structure
- Package midi_pkg:
  - MIDI_NOTE_ON=4'h9, MIDI_NOTE_OFF=4'h8
  - packed struct midi_event_t {note[6:0], velocity[6:0], status}
  - FSM state enum {IDLE, START, DATA, STOP}
- Sub-module midi_event_fifo: synchronous FIFO of midi_event_t with push/pop/count/full/empty. Simultaneous push and pop when full is allowed.
- Top level: FSM, byte builder, bit/baud counters.

## Test plan
- Single note-on (note 60, vel 127) → line carries bytes 0x90, 0x3C, 0x7F; start bit falls 1 cycle after the strobe; each bit is 3200 cycles; line is high after 96000 cycles and busy_out is 0.
- Note-off (note 0x85, vel 0xC0), CHANNEL=3 → bytes 0x83, 0x05, 0x40 (bit 7 masked).
- RUNNING_STATUS=1, two note-ons (60/100, 64/100) → 0x90, 0x3C, 0x64, 0x40, 0x64 with no gap between messages; a following note-off sends 0x80 in full.
- 10 strobes on consecutive cycles, FIFO_DEPTH=8 → first event popped immediately, next 8 queued (fifo_count_out=8), 10th dropped, overflow_out=1 and stays 1 until reset.
- Push while full in the same cycle as a pop → accepted, count unchanged, overflow_out stays 0.
- rst_in low mid-DATA of byte1 → midi_tx_out=1 immediately, all outputs at reset values; after release, a new event transmits a clean 3-byte frame.

Source files
------------

// File: rtl/midi_pkg.sv
// midi_pkg: shared event, state and message types for the MIDI event transmitter
package midi_pkg;
  localparam logic [3:0] MIDI_NOTE_ON = 4'h9;
  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
  typedef struct packed {
    logic [6:0] note;
    logic [6:0] velocity;
    logic       status;
  } midi_event_t;
  localparam int EVENT_W = $bits(midi_event_t);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  function automatic logic [7:0] status_byte(logic status, logic [3:0] channel);
    return {status ? MIDI_NOTE_ON : MIDI_NOTE_OFF, channel};
  endfunction
endpackage

// File: rtl/midi_event_fifo.sv
// midi_event_fifo: synchronous event queue; a push while full is taken when a pop frees the slot
module midi_event_fifo
  import midi_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push,
  input  logic                     pop,
  input  logic [EVENT_W-1:0]       din,
  output logic [EVENT_W-1:0]       dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  midi_event_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr_en, rd_en;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/midi_event_tx.sv
// midi_event_tx: queues note events and serializes them as 8N1 MIDI channel messages
module midi_event_tx
  import midi_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE = 31250,
  parameter int FIFO_DEPTH = 8,
  parameter int CHANNEL = 0,
  parameter int RUNNING_STATUS = 0
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          event_valid_in,
  input  logic [7:0]                    event_note_in,
  input  logic [7:0]                    event_velocity_in,
  input  logic                          event_status_in,
  output logic                          midi_tx_out,
  output logic                          busy_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
  output logic                          overflow_out
);
  localparam int BIT_CYCLES = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int BW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
  tx_state_t state, state_d;
  logic [BW-1:0] baud_cnt;
  logic [2:0] bit_idx;
  logic [1:0] byte_idx;
  logic [2:0][7:0] msg;
  logic [7:0] last_status, head_status;
  logic [EVENT_W-1:0] fifo_dout;
  midi_event_t head;
  logic pop, full, empty, bit_end, unused_msb;
  assign unused_msb = ^{event_note_in[7], event_velocity_in[7]};
  midi_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .push(event_valid_in),
    .pop(pop),
    .din({event_note_in[6:0], event_velocity_in[6:0], event_status_in}),
    .dout(fifo_dout),
    .count(fifo_count_out),
    .full(full),
    .empty(empty)
  );
  assign head = midi_event_t'(fifo_dout);
  assign head_status = status_byte(head.status, 4'(CHANNEL));
  assign bit_end = baud_cnt == BW'(BIT_CYCLES - 1);
  assign busy_out = state != IDLE || !empty;
  assign midi_tx_out = state == START ? 1'b0 : state == DATA ? msg[byte_idx][bit_idx] : 1'b1;
  always_comb begin
    state_d = state;
    pop = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop = 1'b1;
        state_d = START;
      end
      START: if (bit_end) state_d = DATA;
      DATA: if (bit_end && bit_idx == 3'd7) state_d = STOP;
      STOP: if (bit_end) begin
        if (byte_idx != 2'd2) state_d = START;
        else if (!empty) begin
          pop = 1'b1;
          state_d = START;
        end else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
      baud_cnt <= '0;
      bit_idx <= '0;
      byte_idx <= '0;
      msg <= '0;
      last_status <= '0;
      overflow_out <= 1'b0;
    end else begin
      state <= state_d;
      baud_cnt <= (state == IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
      if (state == DATA && bit_end) bit_idx <= bit_idx + 1'b1;
      if (state == STOP && bit_end) byte_idx <= byte_idx + 1'b1;
      // a pop reloads the message; running status starts at the note byte
      if (pop) begin
        msg <= {1'b0, head.velocity, 1'b0, head.note, head_status};
        byte_idx <= (RUNNING_STATUS != 0 && head_status == last_status) ? 2'd1 : 2'd0;
        last_status <= head_status;
      end
      if (event_valid_in && full && !pop) overflow_out <= 1'b1;
    end
  end
endmodule

// File: tb/tb_midi_event_tx.sv
// tb_midi_event_tx: two configurations driven in parallel, checked every cycle against a timeline model
module tb_midi_event_tx;
  localparam int BC = 8;
  typedef struct {
    int d;
    int push;
    int pop;
    int fin;
    logic [2:0][7:0] b;
  } ev_t;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic valid = 1'b0;
  logic [7:0] note = '0, vel = '0;
  logic st = 1'b0;
  logic tx0, tx1, busy0, busy1, ovf0, ovf1;
  logic [3:0] cnt0;
  logic [2:0] cnt1;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  ev_t evq[$];
  int last_end[2];
  logic [7:0] last_st[2];
  int ovf_edge[2];
  midi_event_tx #(.CLOCK_FREQUENCY(250_000), .BAUD_RATE(31250), .FIFO_DEPTH(8),
                  .CHANNEL(0), .RUNNING_STATUS(0)) dut0 (
    .clk_in(clk_in), .rst_in(rst_in), .event_valid_in(valid), .event_note_in(note),
    .event_velocity_in(vel), .event_status_in(st), .midi_tx_out(tx0), .busy_out(busy0),
    .fifo_count_out(cnt0), .overflow_out(ovf0));
  midi_event_tx #(.CLOCK_FREQUENCY(250_000), .BAUD_RATE(31250), .FIFO_DEPTH(4),
                  .CHANNEL(3), .RUNNING_STATUS(1)) dut1 (
    .clk_in(clk_in), .rst_in(rst_in), .event_valid_in(valid), .event_note_in(note),
    .event_velocity_in(vel), .event_status_in(st), .midi_tx_out(tx1), .busy_out(busy1),
    .fifo_count_out(cnt1), .overflow_out(ovf1));
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;
  function automatic int depth_of(int d);
    return d == 0 ? 8 : 4;
  endfunction
  function automatic logic [3:0] ch_of(int d);
    return d == 0 ? 4'd0 : 4'd3;
  endfunction
  function automatic void m_reset();
    evq.delete();
    last_end = '{0, 0};
    last_st = '{8'h00, 8'h00};
    ovf_edge = '{32'h7fffffff, 32'h7fffffff};
  endfunction
  function automatic int m_count(int d, int t);
    int n = 0;
    foreach (evq[i]) if (evq[i].d == d && evq[i].push <= t && evq[i].pop > t) n++;
    return n;
  endfunction
  function automatic logic m_busy(int d, int t);
    foreach (evq[i]) if (evq[i].d == d && evq[i].push <= t && evq[i].fin > t) return 1'b1;
    return 1'b0;
  endfunction
  // line level at cycle t: 10 bit-slots per byte, each BC cycles, from the pop edge
  function automatic logic m_line(int d, int t);
    int o, w;
    logic [7:0] by;
    foreach (evq[i]) if (evq[i].d == d && evq[i].pop <= t && t < evq[i].fin) begin
      o = (t - evq[i].pop) / BC;
      w = o % 10;
      by = evq[i].b[o / 10];
      return w == 0 ? 1'b0 : w == 9 ? 1'b1 : by[w - 1];
    end
    return 1'b1;
  endfunction
  function automatic void m_push(int d, int p, logic [7:0] n, logic [7:0] ve, logic s);
    bit popnow = 0;
    logic [7:0] sb;
    int nb;
    ev_t e;
    foreach (evq[i]) if (evq[i].d == d && evq[i].pop == p) popnow = 1;
    if (m_count(d, p - 1) >= depth_of(d) && !popnow) begin
      if (p < ovf_edge[d]) ovf_edge[d] = p;
      return;
    end
    sb = {s ? 4'h9 : 4'h8, ch_of(d)};
    if (d == 1 && sb == last_st[d]) begin
      e.b = {8'h00, 1'b0, ve[6:0], 1'b0, n[6:0]};
      nb = 2;
    end else begin
      e.b = {1'b0, ve[6:0], 1'b0, n[6:0], sb};
      nb = 3;
    end
    e.d = d;
    e.push = p;
    e.pop = (p + 1 > last_end[d]) ? p + 1 : last_end[d];
    e.fin = e.pop + nb * 10 * BC;
    last_end[d] = e.fin;
    last_st[d] = sb;
    evq.push_back(e);
  endfunction
  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask
  task automatic check_all();
    chk("tx0", 8'(tx0), 8'(m_line(0, cyc)));
    chk("tx1", 8'(tx1), 8'(m_line(1, cyc)));
    chk("busy0", 8'(busy0), 8'(m_busy(0, cyc)));
    chk("busy1", 8'(busy1), 8'(m_busy(1, cyc)));
    chk("count0", 8'(cnt0), 8'(m_count(0, cyc)));
    chk("count1", 8'(cnt1), 8'(m_count(1, cyc)));
    chk("ovf0", 8'(ovf0), 8'(cyc >= ovf_edge[0]));
    chk("ovf1", 8'(ovf1), 8'(cyc >= ovf_edge[1]));
  endtask
  task automatic step(logic v, logic [7:0] n, logic [7:0] ve, logic s);
    @(negedge clk_in);
    check_all();
    valid = v;
    note = n;
    vel = ve;
    st = s;
    if (v) begin
      m_push(0, cyc + 1, n, ve, s);
      m_push(1, cyc + 1, n, ve, s);
    end
  endtask
  task automatic idle(int n);
    repeat (n) step(1'b0, 8'h00, 8'h00, 1'b0);
  endtask
  task automatic do_reset();
    @(negedge clk_in);
    check_all();
    valid = 1'b0;
    #2 rst_in = 1'b0;
    m_reset();
    #1 check_all();
    repeat (2) begin
      @(negedge clk_in);
      check_all();
    end
    rst_in = 1'b1;
  endtask
  initial begin
    m_reset();
    repeat (2) begin
      @(negedge clk_in);
      check_all();
    end
    rst_in = 1'b1;
    step(1'b1, 8'd60, 8'd127, 1'b1);
    idle(250);
    step(1'b1, 8'h85, 8'hC0, 1'b0);
    idle(250);
    step(1'b1, 8'd60, 8'd100, 1'b1);
    step(1'b1, 8'd64, 8'd100, 1'b1);
    idle(5);
    step(1'b1, 8'd60, 8'd0, 1'b0);
    idle(800);
    for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
    idle(2300);
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
    while (cyc + 1 < evq[0].fin) step(1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b1, 8'h11, 8'h22, 1'b1);
    idle(20);
    do_reset();
    step(1'b1, 8'h40, 8'h50, 1'b1);
    idle(13 * BC + 3);
    do_reset();
    step(1'b1, 8'h41, 8'h22, 1'b0);
    idle(260);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
      idle($urandom_range(0, 300));
    end
    idle(3000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
